// File: rtl/icache_pkg.sv
// Shared types for the N-way instruction cache refill controller:
// FSM state encoding and the Execute-stage "no branch" opcode.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    REQ   = 2'd2,
    FILL  = 2'd3
  } state_e;

  localparam logic [1:0] NON_BRANCH = 2'b00;

endpackage

// File: rtl/icache_rr_victim.sv
// Per-set round-robin victim pointers; presents the selected set's victim
// as a one-hot way mask and advances that set's pointer on request.
module icache_rr_victim #(
  parameter int S = 64,
  parameter int N = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [$clog2(S)-1:0] set_sel_i,
  input  logic                 advance_i,
  output logic [N-1:0]         victim_o
);

  generate
    if (N == 1) begin : g_direct
      // Direct-mapped: no pointer state, way 0 is always the victim.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, set_sel_i, advance_i, clk_i, reset_ni};
      assign victim_o = 1'b1;
    end else begin : g_rr
      localparam int PW = $clog2(N);
      logic [PW-1:0] ptr_reg [S];

      // N is a power of two, so natural wrap of the PW-bit pointer is mod N.
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          for (int i = 0; i < S; i++) ptr_reg[i] <= '0;
        end else if (advance_i) begin
          ptr_reg[set_sel_i] <= ptr_reg[set_sel_i] + 1'b1;
        end
      end

      assign victim_o = N'(1) << ptr_reg[set_sel_i];
    end
  endgenerate

endmodule

// File: rtl/instr_cache_ctlr_nway.sv
// N-way instruction cache miss/refill controller with round-robin victims.
// Define ICACHE_PERF_CNT_EN to add free-running hit/miss counters.
module instr_cache_ctlr_nway
  import icache_pkg::*;
#(
  parameter int S = 64,
  parameter int N = 2,
  parameter int B = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [$clog2(S)-1:0] set_i,
  input  logic [N-1:0]         way_hit_i,
  input  logic [1:0]           branch_op_e_i,
  input  logic [1:0]           pc_src_reg_i,
  input  logic                 mem_ready_i,
  input  logic                 mem_valid_i,
  output logic [S-1:0]         active_array_o,
  output logic                 instr_miss_f_o,
  output logic [N-1:0]         way_rep_o,
  output logic [$clog2(B)-1:0] fill_word_o,
  output logic                 mem_req_o,
  output logic                 fill_done_o
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int SW = $clog2(S);
  localparam int BW = $clog2(B);

  state_e          state_reg, state_next;
  logic [SW-1:0]   fill_set_reg;
  logic [N-1:0]    victim_reg;
  logic [BW-1:0]   cnt_reg;
  logic [N-1:0]    victim;
  logic [SW-1:0]   victim_set;
  logic            miss, flush, beat, last_beat;
  logic            unused_pc_src;

  assign miss      = ~|way_hit_i;
  assign flush     = pc_src_reg_i[1];
  assign beat      = (state_reg == FILL) && mem_valid_i;
  assign last_beat = beat && (cnt_reg == BW'(B - 1));
  assign unused_pc_src = &{1'b0, pc_src_reg_i[0]};

  // During a fill the pointer of the latched set is advanced, not set_i's.
  assign victim_set = (state_reg == FILL) ? fill_set_reg : set_i;

  icache_rr_victim #(.S(S), .N(N)) u_victim (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .set_sel_i (victim_set),
    .advance_i (last_beat),
    .victim_o  (victim)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (miss && !flush)
                 state_next = (branch_op_e_i == NON_BRANCH) ? REQ : DELAY;
      DELAY:   state_next = flush ? IDLE : REQ;
      REQ:     if (mem_ready_i) state_next = FILL;
               else if (flush)  state_next = IDLE;
      FILL:    if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      fill_set_reg <= '0;
      victim_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == REQ && mem_ready_i) begin
        fill_set_reg <= set_i;
        victim_reg   <= victim;
      end
      if (beat) cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
    end
  end

  assign active_array_o = S'(1) << set_i;
  assign instr_miss_f_o = (state_reg == IDLE) ? miss : 1'b1;
  assign mem_req_o      = (state_reg == REQ);
  assign way_rep_o      = beat ? victim_reg : '0;
  assign fill_word_o    = cnt_reg;
  assign fill_done_o    = last_beat;

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state_reg == IDLE) begin
      if (!miss)              hit_cnt_o  <= hit_cnt_o + 1'b1;
      if (state_next != IDLE) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache_ctlr_nway.sv
// Directed bench: refill beats are checked by a scoreboard monitor,
// control outputs by direct checks in the stimulus thread.
module tb_instr_cache_ctlr_nway;
  import icache_pkg::*;

  localparam int S = 64;
  localparam int N = 2;
  localparam int B = 4;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [5:0]    set_i;
  logic [N-1:0]  way_hit_i;
  logic [1:0]    branch_op_e_i;
  logic [1:0]    pc_src_reg_i;
  logic          mem_ready_i;
  logic          mem_valid_i;
  logic [S-1:0]  active_array_o;
  logic          instr_miss_f_o;
  logic [N-1:0]  way_rep_o;
  logic [1:0]    fill_word_o;
  logic          mem_req_o;
  logic          fill_done_o;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  typedef struct packed {
    logic [1:0] way;
    logic [1:0] word;
    logic       done;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  beat_t mon_a;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  instr_cache_ctlr_nway #(.S(S), .N(N), .B(B)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .set_i          (set_i),
    .way_hit_i      (way_hit_i),
    .branch_op_e_i  (branch_op_e_i),
    .pc_src_reg_i   (pc_src_reg_i),
    .mem_ready_i    (mem_ready_i),
    .mem_valid_i    (mem_valid_i),
    .active_array_o (active_array_o),
    .instr_miss_f_o (instr_miss_f_o),
    .way_rep_o      (way_rep_o),
    .fill_word_o    (fill_word_o),
    .mem_req_o      (mem_req_o),
    .fill_done_o    (fill_done_o)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every refill beat or done pulse must match the next expected beat.
  always @(negedge clk_i) begin
    if (way_rep_o != '0 || fill_done_o) begin
      mon_a = '{way: way_rep_o, word: fill_word_o, done: fill_done_o};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got way=%b word=%0d done=%b expected none",
                 mon_a.way, mon_a.word, mon_a.done);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          miscompares++;
          $display("FAIL fill_beat: got way=%b word=%0d done=%b expected way=%b word=%0d done=%b",
                   mon_a.way, mon_a.word, mon_a.done, mon_e.way, mon_e.word, mon_e.done);
        end else begin
          $display("beat  set=%0d way=%b word=%0d done=%b", set_i, mon_a.way, mon_a.word, mon_a.done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Miss in 'set', run REQ and nbeats refill beats expecting victim 'way'.
  task automatic do_refill(input logic [5:0] set, input logic [1:0] way,
                           input bit flush_in_req, input int nbeats);
    set_i = set; way_hit_i = '0; branch_op_e_i = NON_BRANCH; pc_src_reg_i = 2'b00;
    #1;
    check("idle_miss_stall", instr_miss_f_o, 1);
    check("idle_no_req", mem_req_o, 0);
    tick();
    check("req_asserted", mem_req_o, 1);
    mem_ready_i = 1'b1;
    if (flush_in_req) pc_src_reg_i = 2'b10;
    for (int i = 0; i < nbeats; i++)
      exp_q.push_back('{way: way, word: 2'(i), done: (i == B - 1)});
    tick();
    mem_ready_i = 1'b0; way_hit_i = 2'b01;
    #1;
    check("fill_no_req", mem_req_o, 0);
    check("fill_stall", instr_miss_f_o, 1);
    check("fill_idle_bus", way_rep_o, 0);
    for (int i = 0; i < nbeats; i++) begin
      mem_valid_i = 1'b1;
      tick();
      if (i == 0) begin
        mem_valid_i = 1'b0;
        #1 check("fill_gap_no_write", way_rep_o, 0);
        tick();
      end
    end
    mem_valid_i = 1'b0;
    if (nbeats == B) begin
      #1;
      check("post_fill_idle_hit", instr_miss_f_o, 0);
      check("post_fill_no_req", mem_req_o, 0);
      pc_src_reg_i = 2'b00;
    end
    $display("refill set=%0d way=%b beats=%0d flush_in_req=%0d", set, way, nbeats, flush_in_req);
  endtask

  initial begin
    reset_ni = 1'b0; set_i = '0; way_hit_i = 2'b01; branch_op_e_i = NON_BRANCH;
    pc_src_reg_i = 2'b00; mem_ready_i = 1'b0; mem_valid_i = 1'b0;
    #2;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_way_rep", way_rep_o, 0);
    check("rst_fill_done", fill_done_o, 0);
    check("rst_fill_word", fill_word_o, 0);
    tick(); tick();
    reset_ni = 1'b1;

    // Hit in set 5, then a multi-hot hit.
    set_i = 6'd5; way_hit_i = 2'b01;
    #1;
    check("hit_no_stall", instr_miss_f_o, 0);
    check("hit_active_array", active_array_o, 64'd1 << 5);
    check("hit_no_req", mem_req_o, 0);
    way_hit_i = 2'b11;
    #1 check("multihot_hit", instr_miss_f_o, 0);
    set_i = 6'd63;
    #1 check("active_array_top", active_array_o, 64'd1 << 63);
    tick();
    $display("hit   checks done");

    // Round-robin in set 3, independent pointer in set 7.
    do_refill(6'd3, 2'b01, 1'b0, B);
    do_refill(6'd3, 2'b10, 1'b0, B);
    do_refill(6'd3, 2'b01, 1'b0, B);
    do_refill(6'd7, 2'b01, 1'b0, B);

    // Miss with branch in Execute, then redirect: DELAY -> IDLE, no request.
    set_i = 6'd9; way_hit_i = '0; branch_op_e_i = 2'b01; pc_src_reg_i = 2'b00;
    tick();
    check("delay_stall", instr_miss_f_o, 1);
    check("delay_no_req", mem_req_o, 0);
    pc_src_reg_i = 2'b10;
    tick();
    check("delay_flush_no_req", mem_req_o, 0);
    tick();
    check("wrong_path_no_req", mem_req_o, 0);
    way_hit_i = 2'b01; pc_src_reg_i = 2'b00; branch_op_e_i = NON_BRANCH;
    #1 check("branch_resume_hit", instr_miss_f_o, 0);
    tick();
    $display("branch flush sequence done");

    // REQ abandoned by redirect while memory is not ready.
    set_i = 6'd4; way_hit_i = '0;
    tick();
    check("req_abort_req", mem_req_o, 1);
    pc_src_reg_i = 2'b10;
    tick();
    check("req_abort_to_idle", mem_req_o, 0);
    way_hit_i = 2'b01; pc_src_reg_i = 2'b00;
    tick();
    $display("req abort sequence done");

    // Asynchronous reset after the second beat of a fill.
    do_refill(6'd3, 2'b10, 1'b0, 2);
    mem_valid_i = 1'b1;
    reset_ni = 1'b0;
    #1;
    check("async_rst_way_rep", way_rep_o, 0);
    check("async_rst_mem_req", mem_req_o, 0);
    check("async_rst_fill_done", fill_done_o, 0);
    check("async_rst_idle_hit", instr_miss_f_o, 0);
    tick();
    mem_valid_i = 1'b0;
    reset_ni = 1'b1;
    $display("reset mid-fill done");
    do_refill(6'd3, 2'b01, 1'b0, B);

    // mem_ready_i and redirect together in REQ: ready wins.
    do_refill(6'd3, 2'b10, 1'b1, B);

    tick();
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
